// File: rtl/wb_master_bridge.sv
// Bridges the PicoRV32 native memory interface onto Wishbone B4 classic single cycles,
// with a bus timeout and an error return so an absent or faulting responder cannot hang the core.
module wb_master_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic        mem_ready_o,
    output logic [31:0] mem_rdata_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    output logic        we_o,
    output logic [3:0]  sel_o,
    output logic        cyc_o,
    output logic        stb_o,
    input  logic        ack_i,
    input  logic        err_i,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        cyc_q, cyc_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        berr_q, berr_d;

    // Byte offset bits are dropped: Wishbone addresses are word aligned.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^mem_addr_i[1:0];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (mem_valid_i) state_d = BUS;
            BUS:  if (err_i || ack_i || (cnt_q == TMO_LAST)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Every output is computed here as a next value and registered below.
    always_comb begin
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        we_d    = we_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        berr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (mem_valid_i) begin
                    adr_d = {mem_addr_i[31:2], 2'b00};
                    dat_d = mem_wdata_i;
                    we_d  = |mem_wstrb_i;
                    sel_d = (|mem_wstrb_i) ? mem_wstrb_i : 4'hF;
                    cyc_d = 1'b1;
                end
            end
            BUS: begin
                if (err_i) begin
                    cyc_d   = 1'b0;
                    rdata_d = ERR_DATA;
                    berr_d  = 1'b1;
                    ready_d = 1'b1;
                end else if (ack_i) begin
                    cyc_d   = 1'b0;
                    ready_d = 1'b1;
                    if (!we_q) rdata_d = dat_i;
                end else if (cnt_q == TMO_LAST) begin
                    cyc_d   = 1'b0;
                    rdata_d = ERR_DATA;
                    berr_d  = 1'b1;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                cyc_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            berr_q  <= berr_d;
        end
    end

    assign cyc_o       = cyc_q;
    assign stb_o       = cyc_q;
    assign adr_o       = adr_q;
    assign dat_o       = dat_q;
    assign we_o        = we_q;
    assign sel_o       = sel_q;
    assign mem_rdata_o = rdata_q;
    assign mem_ready_o = ready_q;
    assign bus_err_o   = berr_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Directed bench for wb_master_bridge: registered-ack responder model plus forced ack/err,
// TIMEOUT set to 4 so the abort path is reached quickly.
module tb_wb_master_bridge;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        mem_valid_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_wstrb_i;
    logic        mem_ready_o;
    logic [31:0] mem_rdata_o;
    logic [31:0] adr_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        we_o;
    logic [3:0]  sel_o;
    logic        cyc_o;
    logic        stb_o;
    logic        ack_i;
    logic        err_i;
    logic        bus_err_o;

    logic        resp_en;
    logic        ack_reg;
    logic        ack_force;
    logic        err_force;
    logic        stb_prev;
    int          stb_rises;
    int          ready_pulses;
    int          n_assert;
    int          n_fail;

    always #5 clk = ~clk;

    wb_master_bridge #(.TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .mem_valid_i(mem_valid_i),
        .mem_addr_i (mem_addr_i),
        .mem_wdata_i(mem_wdata_i),
        .mem_wstrb_i(mem_wstrb_i),
        .mem_ready_o(mem_ready_o),
        .mem_rdata_o(mem_rdata_o),
        .adr_o      (adr_o),
        .dat_o      (dat_o),
        .dat_i      (dat_i),
        .we_o       (we_o),
        .sel_o      (sel_o),
        .cyc_o      (cyc_o),
        .stb_o      (stb_o),
        .ack_i      (ack_i),
        .err_i      (err_i),
        .bus_err_o  (bus_err_o)
    );

    // Registered responder: acks one cycle after it sees strobe, so it also acks once more in DONE.
    always @(posedge clk) ack_reg <= resp_en & cyc_o & stb_o;
    assign ack_i = ack_reg | ack_force;
    assign err_i = err_force;

    always @(posedge clk) begin
        stb_prev <= stb_o;
        if (stb_o && !stb_prev) stb_rises <= stb_rises + 1;
        if (mem_ready_o) ready_pulses <= ready_pulses + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        mem_valid_i = 1'b1;
        mem_addr_i  = a;
        mem_wdata_i = d;
        mem_wstrb_i = s;
    endtask

    initial begin
        int rises0;
        int ready0;
        int waited;
        ack_reg      = 1'b0;
        stb_prev     = 1'b0;
        stb_rises    = 0;
        ready_pulses = 0;
        n_assert     = 0;
        n_fail       = 0;
        resp_en      = 1'b1;
        ack_force    = 1'b0;
        err_force    = 1'b0;
        dat_i        = 32'h1234_5678;
        rst_ni       = 1'b0;
        request(32'h0000_1006, 32'h0, 4'b0000);

        // Reset held with a pending request
        repeat (3) tick();
        check("rst_cyc",   {31'b0, cyc_o}, 32'd0);
        check("rst_stb",   {31'b0, stb_o}, 32'd0);
        check("rst_ready", {31'b0, mem_ready_o}, 32'd0);
        check("rst_berr",  {31'b0, bus_err_o}, 32'd0);
        check("rst_we",    {31'b0, we_o}, 32'd0);
        check("rst_adr",   adr_o, 32'd0);
        check("rst_dat",   dat_o, 32'd0);
        check("rst_sel",   {28'b0, sel_o}, 32'd0);
        check("rst_rdata", mem_rdata_o, 32'd0);

        // Read, registered responder
        rst_ni = 1'b1;
        tick();
        check("rd_cyc", {31'b0, cyc_o}, 32'd1);
        check("rd_stb", {31'b0, stb_o}, 32'd1);
        check("rd_adr", adr_o, 32'h0000_1004);
        check("rd_we",  {31'b0, we_o}, 32'd0);
        check("rd_sel", {28'b0, sel_o}, 32'hF);
        mem_valid_i = 1'b0;
        tick();
        check("rd_ready_e1", {31'b0, mem_ready_o}, 32'd0);
        check("rd_cyc_e1",   {31'b0, cyc_o}, 32'd1);
        tick();
        check("rd_ready_e2", {31'b0, mem_ready_o}, 32'd1);
        check("rd_rdata",    mem_rdata_o, 32'h1234_5678);
        check("rd_berr",     {31'b0, bus_err_o}, 32'd0);
        check("rd_cyc_e2",   {31'b0, cyc_o}, 32'd0);
        tick();
        check("rd_ready_e3", {31'b0, mem_ready_o}, 32'd0);
        tick();
        check("rd_one_ready", 32'(ready_pulses), 32'd1);
        check("rd_one_cycle", 32'(stb_rises), 32'd1);

        // Write; the duplicate ack lands in DONE
        rises0 = stb_rises;
        ready0 = ready_pulses;
        dat_i  = 32'h0;
        request(32'h0000_2003, 32'hCAFE_F00D, 4'b0011);
        tick();
        check("wr_we",  {31'b0, we_o}, 32'd1);
        check("wr_sel", {28'b0, sel_o}, 32'h3);
        check("wr_dat", dat_o, 32'hCAFE_F00D);
        check("wr_adr", adr_o, 32'h0000_2000);
        mem_valid_i = 1'b0;
        tick();
        tick();
        check("wr_ready", {31'b0, mem_ready_o}, 32'd1);
        check("wr_rdata_kept", mem_rdata_o, 32'h1234_5678);
        tick();
        check("wr_ready_clr", {31'b0, mem_ready_o}, 32'd0);
        check("wr_cyc_done",  {31'b0, cyc_o}, 32'd0);
        repeat (3) tick();
        check("wr_one_cycle", 32'(stb_rises - rises0), 32'd1);
        check("wr_one_ready", 32'(ready_pulses - ready0), 32'd1);

        // err_i and ack_i together: error wins
        resp_en = 1'b0;
        dat_i   = 32'h5555_5555;
        request(32'h0000_4000, 32'h0, 4'b0000);
        tick();
        mem_valid_i = 1'b0;
        ack_force   = 1'b1;
        err_force   = 1'b1;
        tick();
        check("pri_ready", {31'b0, mem_ready_o}, 32'd1);
        check("pri_rdata", mem_rdata_o, 32'hDEAD_BEEF);
        check("pri_berr",  {31'b0, bus_err_o}, 32'd1);
        ack_force = 1'b0;
        err_force = 1'b0;
        tick();
        check("pri_berr_clr", {31'b0, bus_err_o}, 32'd0);
        tick();

        // Ordinary read to move rdata away from ERR_DATA
        resp_en = 1'b1;
        dat_i   = 32'hA5A5_0F0F;
        request(32'h0000_5008, 32'h0, 4'b0000);
        tick();
        mem_valid_i = 1'b0;
        tick();
        tick();
        check("rd2_rdata", mem_rdata_o, 32'hA5A5_0F0F);
        repeat (2) tick();

        // Timeout with no responder
        resp_en = 1'b0;
        request(32'h0000_3000, 32'h0, 4'b0000);
        tick();
        mem_valid_i = 1'b0;
        check("to_stb_e0", {31'b0, stb_o}, 32'd1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check($sformatf("to_stb_e%0d", i), {31'b0, stb_o}, 32'd1);
            check($sformatf("to_ready_e%0d", i), {31'b0, mem_ready_o}, 32'd0);
        end
        tick();
        check("to_stb_end", {31'b0, stb_o}, 32'd0);
        check("to_ready",   {31'b0, mem_ready_o}, 32'd1);
        check("to_berr",    {31'b0, bus_err_o}, 32'd1);
        check("to_rdata",   mem_rdata_o, 32'hDEAD_BEEF);
        tick();
        check("to_ready_clr", {31'b0, mem_ready_o}, 32'd0);
        check("to_berr_clr",  {31'b0, bus_err_o}, 32'd0);
        tick();

        // Reset while in BUS drops the cycle
        request(32'h0000_6000, 32'h0, 4'b0000);
        tick();
        mem_valid_i = 1'b0;
        tick();
        check("mr_cyc_before", {31'b0, cyc_o}, 32'd1);
        ready0 = ready_pulses;
        rst_ni = 1'b0;
        tick();
        check("mr_cyc",   {31'b0, cyc_o}, 32'd0);
        check("mr_ready", {31'b0, mem_ready_o}, 32'd0);
        check("mr_adr",   adr_o, 32'd0);
        rst_ni = 1'b1;
        repeat (5) tick();
        check("mr_no_ready", 32'(ready_pulses - ready0), 32'd0);

        resp_en = 1'b1;
        dat_i   = 32'h0BAD_CAFE;
        request(32'h0000_7004, 32'h0, 4'b0000);
        tick();
        mem_valid_i = 1'b0;
        waited = 0;
        while (!mem_ready_o && waited < 10) begin
            tick();
            waited++;
        end
        check("mr_post_ready", {31'b0, mem_ready_o}, 32'd1);
        check("mr_post_rdata", mem_rdata_o, 32'h0BAD_CAFE);
        check("mr_post_lat",   32'(waited), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_master_bridge.md
# wb_master_bridge

Wishbone classic single-cycle initiator that converts the PicoRV32 native memory interface (mem_valid/mem_ready) into Wishbone B4 classic bus cycles. It sits between the CPU core and the Wishbone interconnect, driving register-style responders that ack one cycle after strobe. It also provides a bus timeout and error return, so that a missing or faulting responder cannot hang the core.

## Interface
Parameters:
- TIMEOUT, 255: cycles a strobe may stay unacknowledged before abort (1..255; counter is 8 bits).
- ERR_DATA, 32'hDEAD_BEEF: read data returned to the core on timeout or err_i.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_ni  in  1  synchronous active-low reset.
- mem_valid_i  in  1  core request valid.
- mem_addr_i  in  32  core byte address.
- mem_wdata_i  in  32  core write data.
- mem_wstrb_i  in  4  byte write strobes; 4'b0000 = read.
- mem_ready_o  out  1  one-cycle completion pulse to core.
- mem_rdata_o  out  32  read data, valid while mem_ready_o=1.
- adr_o  out  32  Wishbone address, word aligned.
- dat_o  out  32  Wishbone write data.
- dat_i  in  32  Wishbone read data.
- we_o  out  1  write enable.
- sel_o  out  4  byte selects.
- cyc_o  out  1  cycle.
- stb_o  out  1  strobe.
- ack_i  in  1  responder acknowledge.
- err_i  in  1  responder error.
- bus_err_o  out  1  one-cycle pulse on timeout or err_i completion.

## Operation
- All outputs are registered. Reset (rst_ni=0 at an edge) forces state IDLE and drives every output to 0, including mem_rdata_o, adr_o, dat_o and sel_o. The timeout counter is cleared.
- An in-flight transaction is dropped on reset: cyc_o/stb_o fall at the reset edge and no mem_ready_o is issued.
- States: IDLE, BUS, DONE.
- IDLE:
  - If mem_valid_i=1, latch the request and go to BUS.
  - adr_o = {mem_addr_i[31:2],2'b00}.
  - dat_o = mem_wdata_i.
  - we_o = |mem_wstrb_i.
  - sel_o = mem_wstrb_i for writes, 4'hF for reads.
  - cyc_o = stb_o = 1.
  - Clear the counter.
- BUS: cyc_o, stb_o, adr_o, dat_o, we_o and sel_o are held stable. At each edge, the first matching case applies:
  - err_i=1: go to DONE. cyc_o=stb_o=0, mem_rdata_o=ERR_DATA, bus_err_o=1, mem_ready_o=1.
  - ack_i=1: go to DONE. cyc_o=stb_o=0, mem_ready_o=1. For reads, mem_rdata_o=dat_i; for writes, mem_rdata_o is unchanged.
  - counter == TIMEOUT-1: treated exactly as err_i (abort with ERR_DATA and bus_err_o).
  - otherwise: counter increments.
- Priority when err_i and ack_i are both high: err_i wins.
- DONE: the next edge clears mem_ready_o and bus_err_o and returns to IDLE.
- ack_i and err_i are ignored in IDLE and DONE. A responder that holds ack for an extra cycle, because it still sampled stb at the ack edge, is therefore harmless.
- Back-to-back transfers: mem_valid_i is sampled again in IDLE, so a fresh request held by the core after mem_ready_o is issued as a new cycle. It is never re-issued from DONE.
- mem_valid_i dropping while in BUS is ignored; the cycle completes normally.

## Timing
- Edge E0: IDLE samples mem_valid_i=1. cyc_o/stb_o are high from E0.
- Zero-wait (combinational ack) responder: ack sampled at E1; mem_ready_o is high E1–E2; IDLE at E2. Request-to-ready is 1 cycle, and each transfer occupies 3 cycles.
- Registered responder (ack one cycle after stb): ack rises at E1 and is sampled at E2; mem_ready_o is high E2–E3.
- Timeout: with no ack, the abort edge is E(TIMEOUT). stb_o is high for exactly TIMEOUT cycles.
- mem_ready_o and bus_err_o are never high for more than one consecutive cycle.
- cyc_o is never asserted in DONE, so a new cycle never begins with stb_o high.

## Test plan
- Reset: hold rst_ni=0 for 3 cycles with mem_valid_i=1 → all outputs 0 and state IDLE. Release → cyc_o rises on the next edge.
- Read: registered-ack responder returns dat_i=32'h1234_5678; core reads addr 32'h0000_1006 → adr_o=32'h0000_1004, we_o=0, sel_o=4'hF. mem_ready_o pulses exactly once, 2 edges after acceptance, with mem_rdata_o=32'h1234_5678.
- Write: wstrb=4'b0011, wdata=32'hCAFE_F00D → we_o=1, sel_o=4'b0011, dat_o=32'hCAFE_F00D. One mem_ready_o pulse; the duplicate ack in DONE is ignored (exactly one Wishbone cycle).
- Timeout: TIMEOUT=4, ack_i tied 0 → stb_o high exactly 4 cycles, then mem_ready_o=1, bus_err_o=1 and mem_rdata_o=32'hDEAD_BEEF in the same cycle.
- Error priority: ack_i=err_i=1 together → mem_rdata_o=ERR_DATA, bus_err_o=1.
- Reset mid-cycle: rst_ni=0 while in BUS → cyc_o=0 at that edge and no mem_ready_o. A request after release completes normally.
